inst_fetch_buffer: RTL and testbench

Instruction-fetch stage directly upstream of the out-of-order core. It accepts fetch requests carrying an id and PC, reads a loadable program memory with a fixed 1-cycle latency, and buffers the decoded instructions in an in-order FIFO. It presents them on the core's issue handshake, including the last-instruction flag. Program contents survive reset, so a program loaded once can be re-run.

---
 rtl/inst_fetch_buffer.sv | 122 ++++++++++++
 tb/tb_inst_fetch_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: the program RAM is read on the fetch handshake, and decoded words queue in order toward the core.
// Latency: a handshake in cycle T reaches stage 1 in T+1 and the FIFO head in T+2; there is no bypass.
// Backpressure: a credit check on FIFO occupancy plus stage 1 gates fetch_rdy, so inst_rdy never stalls stage 1.
module inst_fetch_buffer #(
  parameter int NUM_FU      = 8,
  parameter int NUM_REG     = 8,
  parameter int IMM_BIT     = 4,
  parameter int INST_ID_BIT = 8,
  parameter int PC_BIT      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int INST_BIT    = $clog2(NUM_FU) + 3 * $clog2(NUM_REG) + IMM_BIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_wr_vld,
  input  logic [PC_BIT-1:0]          prog_wr_addr,
  input  logic [INST_BIT-1:0]        prog_wr_data,
  input  logic                       prog_wr_last,
  input  logic                       fetch_vld,
  output logic                       fetch_rdy,
  input  logic [INST_ID_BIT-1:0]     fetch_id,
  input  logic [PC_BIT-1:0]          fetch_pc,
  output logic                       inst_vld,
  input  logic                       inst_rdy,
  output logic                       inst_last,
  output logic [$clog2(NUM_FU)-1:0]  inst_op,
  output logic [INST_ID_BIT-1:0]     inst_id,
  output logic [$clog2(NUM_REG)-1:0] inst_dst_reg,
  output logic [$clog2(NUM_REG)-1:0] inst_src_reg0,
  output logic [$clog2(NUM_REG)-1:0] inst_src_reg1,
  output logic [IMM_BIT-1:0]         inst_imm
);

  localparam int OP_BIT     = $clog2(NUM_FU);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int PTR_BIT    = $clog2(FIFO_DEPTH);
  localparam int CNT_BIT    = PTR_BIT + 1;

  typedef struct packed {
    logic                   last;
    logic [INST_BIT-1:0]    word;
    logic [INST_ID_BIT-1:0] id;
  } entry_t;

  logic [INST_BIT:0]      prog_mem [2**PC_BIT];
  logic [INST_BIT:0]      rd_dat;
  logic                   fetch_hs;
  logic                   s1_vld;
  logic [INST_ID_BIT-1:0] s1_id;
  entry_t                 push_dat;
  entry_t                 fifo_mem [FIFO_DEPTH];
  entry_t                 head;
  entry_t                 out_dat;
  logic [PTR_BIT-1:0]     wr_ptr;
  logic [PTR_BIT-1:0]     rd_ptr;
  logic [CNT_BIT-1:0]     count;
  logic [CNT_BIT-1:0]     occ;
  logic                   pop;

  assign fetch_hs = fetch_vld && fetch_rdy;

  // Program RAM is never reset; the non-blocking read makes a colliding write read-first.
  always_ff @(posedge clk) begin
    if (prog_wr_vld) prog_mem[prog_wr_addr] <= {prog_wr_last, prog_wr_data};
    if (fetch_hs)    rd_dat <= prog_mem[fetch_pc];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
    end else begin
      s1_vld <= fetch_hs;
      if (fetch_hs) s1_id <= fetch_id;
    end
  end

  assign push_dat.last = rd_dat[INST_BIT];
  assign push_dat.word = rd_dat[INST_BIT-1:0];
  assign push_dat.id   = s1_id;

  // The credit counts the stage-1 entry, so a push always finds room.
  assign occ       = count + CNT_BIT'(s1_vld);
  assign fetch_rdy = !rst && (occ < CNT_BIT'(FIFO_DEPTH));

  assign head     = fifo_mem[rd_ptr];
  assign inst_vld = !rst && (count != '0);
  assign pop      = inst_vld && inst_rdy;

  always_ff @(posedge clk) begin
    if (s1_vld) fifo_mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (s1_vld) wr_ptr <= wr_ptr + PTR_BIT'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_BIT'(1);
      unique case ({s1_vld, pop})
        2'b10:   count <= count + CNT_BIT'(1);
        2'b01:   count <= count - CNT_BIT'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_dat       = inst_vld ? head : '0;
  assign inst_last     = out_dat.last;
  assign inst_id       = out_dat.id;
  assign inst_op       = out_dat.word[INST_BIT-1 -: OP_BIT];
  assign inst_dst_reg  = out_dat.word[INST_BIT-OP_BIT-1 -: REG_ID_BIT];
  assign inst_src_reg0 = out_dat.word[INST_BIT-OP_BIT-REG_ID_BIT-1 -: REG_ID_BIT];
  assign inst_src_reg1 = out_dat.word[INST_BIT-OP_BIT-2*REG_ID_BIT-1 -: REG_ID_BIT];
  assign inst_imm      = out_dat.word[IMM_BIT-1:0];

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(s1_vld && !pop && count == CNT_BIT'(FIFO_DEPTH)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: reset, latency, backpressure, streaming, last flag, collision, mid-op reset.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_wr_vld, prog_wr_last;
  logic [7:0]  prog_wr_addr;
  logic [15:0] prog_wr_data;
  logic        fetch_vld, fetch_rdy;
  logic [7:0]  fetch_id, fetch_pc;
  logic        inst_vld, inst_rdy, inst_last;
  logic [2:0]  inst_op, inst_dst_reg, inst_src_reg0, inst_src_reg1;
  logic [7:0]  inst_id;
  logic [3:0]  inst_imm;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int hs_cnt, pop_cnt, last_cnt, first_hs, first_pop, last_pop;
  logic [16:0] mem_m [256];
  logic [24:0] exp_q [$];
  logic [15:0] wtab [8] = '{16'h3A5C, 16'h1234, 16'h5678, 16'h9ABC,
                            16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A};
  logic [15:0] head_word;

  assign head_word = {inst_op, inst_dst_reg, inst_src_reg0, inst_src_reg1, inst_imm};

  inst_fetch_buffer dut (
    .clk(clk), .rst(rst),
    .prog_wr_vld(prog_wr_vld), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .prog_wr_last(prog_wr_last),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_id(fetch_id), .fetch_pc(fetch_pc),
    .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_last(inst_last), .inst_op(inst_op),
    .inst_id(inst_id), .inst_dst_reg(inst_dst_reg), .inst_src_reg0(inst_src_reg0),
    .inst_src_reg1(inst_src_reg1), .inst_imm(inst_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    hs_cnt = 0; pop_cnt = 0; last_cnt = 0; first_hs = 0; first_pop = 0; last_pop = 0;
  endtask

  // Called at a negedge: drives inputs for the next posedge, scores pops and handshakes.
  task automatic step(input logic fv, input logic [7:0] pc, input logic [7:0] id, input logic rdy);
    fetch_vld = fv; fetch_pc = pc; fetch_id = id; inst_rdy = rdy;
    if (inst_vld && rdy) begin
      if (exp_q.size() == 0) check("spurious_pop", 32'(inst_vld), 32'd0);
      else check("pop_entry", 32'({inst_last, head_word, inst_id}), 32'(exp_q.pop_front()));
      if (pop_cnt == 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
      if (inst_last) last_cnt++;
    end
    if (fv && fetch_rdy) begin
      exp_q.push_back({mem_m[pc], id});
      if (hs_cnt == 0) first_hs = cyc;
      hs_cnt++;
    end
    if (prog_wr_vld) mem_m[prog_wr_addr] = {prog_wr_last, prog_wr_data};
    @(posedge clk);
    cyc++;
    @(negedge clk);
    prog_wr_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_vld = 1'b1; fetch_pc = '0; fetch_id = '0; inst_rdy = 1'b1;
    prog_wr_vld = 1'b0; prog_wr_addr = '0; prog_wr_data = '0; prog_wr_last = 1'b0;
    clr();

    repeat (2) begin
      @(negedge clk);
      check("rst_fetch_rdy", 32'(fetch_rdy), 32'd0);
      check("rst_inst_vld", 32'(inst_vld), 32'd0);
      check("rst_inst_op", 32'(inst_op), 32'd0);
    end
    rst = 1'b0; fetch_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_rdy", 32'(fetch_rdy), 32'd1);
    check("post_rst_vld", 32'(inst_vld), 32'd0);

    for (int i = 0; i < 8; i++) begin
      prog_wr_vld = 1'b1; prog_wr_addr = 8'(i); prog_wr_data = wtab[i]; prog_wr_last = (i == 2);
      step(1'b0, 8'd0, 8'd0, 1'b1);
    end
    prog_wr_last = 1'b0;

    // Single fetch: 3A5C decodes to op 1, dst 6, src0 4, src1 5, imm C.
    clr();
    step(1'b1, 8'd0, 8'd5, 1'b1);
    check("t1_vld", 32'(inst_vld), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("t2_vld", 32'(inst_vld), 32'd1);
    check("t2_op", 32'(inst_op), 32'd1);
    check("t2_dst", 32'(inst_dst_reg), 32'd6);
    check("t2_src0", 32'(inst_src_reg0), 32'd4);
    check("t2_src1", 32'(inst_src_reg1), 32'd5);
    check("t2_imm", 32'(inst_imm), 32'hC);
    check("t2_id", 32'(inst_id), 32'd5);
    check("t2_last", 32'(inst_last), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("t3_vld", 32'(inst_vld), 32'd0);

    // Backpressure.
    clr();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 8'(i), 1'b0);
    check("bp_accepts", 32'(hs_cnt), 32'd4);
    check("bp_rdy_low", 32'(fetch_rdy), 32'd0);
    check("bp_head_word", 32'(head_word), 32'h3A5C);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    check("bp_hold_id", 32'(inst_id), 32'd0);
    check("bp_hold_word", 32'(head_word), 32'h3A5C);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("bp_rdy_after_pop", 32'(fetch_rdy), 32'd1);
    repeat (4) step(1'b0, 8'd0, 8'd0, 1'b1);
    check("bp_pops", 32'(pop_cnt), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Streaming: pc2 appears at i = 2, 10, 18.
    clr();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i % 8), 8'(100 + i), 1'b1);
    repeat (3) step(1'b0, 8'd0, 8'd0, 1'b1);
    check("st_accepts", 32'(hs_cnt), 32'd20);
    check("st_pops", 32'(pop_cnt), 32'd20);
    check("st_offset", 32'(first_pop - first_hs), 32'd2);
    check("st_span", 32'(last_pop - first_pop), 32'd19);
    check("st_last_cnt", 32'(last_cnt), 32'd3);

    // Collision: write pc1 while fetching it.
    clr();
    prog_wr_vld = 1'b1; prog_wr_addr = 8'd1; prog_wr_data = 16'hC3E1; prog_wr_last = 1'b0;
    step(1'b1, 8'd1, 8'd50, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("col_old_word", 32'(head_word), 32'h1234);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd1, 8'd51, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("col_new_word", 32'(head_word), 32'hC3E1);
    check("col_new_id", 32'(inst_id), 32'd51);
    step(1'b0, 8'd0, 8'd0, 1'b1);

    // Mid-operation reset with 3 buffered plus stage 1 valid.
    clr();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 8'(60 + i), 1'b0);
    check("mr_accepts", 32'(hs_cnt), 32'd4);
    check("mr_buffered", 32'(inst_vld), 32'd1);
    rst = 1'b1;
    step(1'b0, 8'd0, 8'd0, 1'b0);
    check("mr_rst_vld", 32'(inst_vld), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    clr();
    repeat (5) step(1'b0, 8'd0, 8'd0, 1'b1);
    check("mr_no_output", 32'(pop_cnt), 32'd0);
    check("mr_rdy", 32'(fetch_rdy), 32'd1);
    step(1'b1, 8'd0, 8'd70, 1'b1);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("mr_refetch_word", 32'(head_word), 32'h3A5C);
    check("mr_refetch_id", 32'(inst_id), 32'd70);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
